// File: rtl/pipelined_cla_subtractor.sv
// rtl/pipelined_cla_subtractor.sv - pipelined carry-lookahead subtractor, D = A - B - bin
//
// Computes A + ~B + ~bin one SLICE-bit slice per pipeline stage, with 4-bit
// lookahead groups inside each slice and the slice carry registered between
// stages. Operands travel down the pipe with the op; result slices accumulate
// into the op's difference word. All stages advance together (global stall).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake for a, b, bin
//   a, b, bin             minuend, subtrahend, borrow-in
//   out_valid / out_ready result handshake for diff and flags
//   diff                  A - B - bin modulo 2^WIDTH
//   bout                  borrow-out (unsigned A < B + bin)
//   ovf                   signed overflow of the subtraction
//   zero                  diff == 0
module pipelined_cla_subtractor #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4,
    parameter int SLICE  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int GROUPS = SLICE / 4;

    // 4-bit carry-lookahead group: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    // One slice: lookahead groups chained group-to-group; returns {carry_out, sum}
    function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x, input logic [SLICE-1:0] y,
                                                 input logic ci);
        logic [SLICE-1:0] s;
        logic             c;
        logic [4:0]       r;
        s = '0;
        c = ci;
        for (int gi = 0; gi < GROUPS; gi++) begin
            r              = cla4(x[4*gi +: 4], y[4*gi +: 4], c);
            s[4*gi +: 4]   = r[3:0];
            c              = r[4];
        end
        return {c, s};
    endfunction

    // Inter-stage registers (stage k feeds stage k+1); the last stage feeds the outputs
    logic [STAGES-2:0] vld;
    logic [WIDTH-1:0]  a_q [STAGES-1];
    logic [WIDTH-1:0]  b_q [STAGES-1];
    logic [WIDTH-1:0]  d_q [STAGES-1];
    logic              c_q [STAGES-1];

    // Per-stage combinational view of the op currently entering that stage's register
    logic [WIDTH-1:0]  sa    [STAGES];
    logic [WIDTH-1:0]  sb    [STAGES];
    logic [WIDTH-1:0]  dprev [STAGES];
    logic [WIDTH-1:0]  sd    [STAGES];
    logic              cin   [STAGES];
    logic [SLICE:0]    r     [STAGES];

    logic adv;
    logic rdy_q;

    assign adv      = !out_valid || out_ready;
    // rdy_q holds in_ready low through reset and until the first clock after release
    assign in_ready = rdy_q && adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SMASK = {{(WIDTH-SLICE){1'b0}}, {SLICE{1'b1}}} << (k*SLICE);
        if (k == 0) begin : g_first
            assign sa[k]    = a;
            assign sb[k]    = b;
            assign cin[k]   = ~bin;
            assign dprev[k] = '0;
        end else begin : g_rest
            assign sa[k]    = a_q[k-1];
            assign sb[k]    = b_q[k-1];
            assign cin[k]   = c_q[k-1];
            assign dprev[k] = d_q[k-1];
        end
        assign r[k]  = slice_add(sa[k][k*SLICE +: SLICE], ~sb[k][k*SLICE +: SLICE], cin[k]);
        assign sd[k] = (dprev[k] & ~SMASK)
                     | ({{(WIDTH-SLICE){1'b0}}, r[k][SLICE-1:0]} << (k*SLICE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            vld       <= '0;
            for (int k = 0; k < STAGES-1; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                d_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (adv) begin
                vld[0] <= in_valid && in_ready;
                for (int k = 1; k < STAGES-1; k++) begin
                    vld[k] <= vld[k-1];
                end
                for (int k = 0; k < STAGES-1; k++) begin
                    a_q[k] <= sa[k];
                    b_q[k] <= sb[k];
                    d_q[k] <= sd[k];
                    c_q[k] <= r[k][SLICE];
                end
                out_valid <= vld[STAGES-2];
                diff      <= sd[STAGES-1];
                bout      <= ~r[STAGES-1][SLICE];
                ovf       <= (sa[STAGES-1][WIDTH-1] ^ sb[STAGES-1][WIDTH-1])
                           & (sd[STAGES-1][WIDTH-1] ^ sa[STAGES-1][WIDTH-1]);
                zero      <= ~|sd[STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// tb/tb_pipelined_cla_subtractor.sv - self-checking bench for pipelined_cla_subtractor
module tb_pipelined_cla_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic        bin_i;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    pipelined_cla_subtractor #(.WIDTH(64), .STAGES(4), .SLICE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .bin       (bin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out = 0;
    int   cyc = 0;
    int   phase_base = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;

    localparam logic signed [65:0] SMAX = $signed({3'b000, {63{1'b1}}});
    localparam logic signed [65:0] SMIN = $signed({3'b111, 63'd0});

    // Reference: plain wide arithmetic, unsigned and signed
    function automatic res_t model(input logic [63:0] x, input logic [63:0] y, input logic bi);
        res_t             rr;
        logic [64:0]      u;
        logic signed [65:0] s;
        u     = {1'b0, x} - {1'b0, y} - {64'd0, bi};
        s     = $signed({x[63], x[63], x}) - $signed({y[63], y[63], y}) - $signed({65'd0, bi});
        rr.d  = u[63:0];
        rr.bo = u[64];
        rr.ov = (s > SMAX) || (s < SMIN);
        rr.z  = (u[63:0] == 64'd0);
        return rr;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Compare process: model push on accept, pop and compare on each output handshake
    logic        prev_stall = 1'b0;
    logic [66:0] prev_out = '0;
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
            if (prev_stall)
                chk("stall_hold", {60'd0, out_valid, bout, ovf, zero, diff[3:0]} ^ {diff ^ prev_out[63:0]},
                    {60'd0, 1'b1, prev_out[66:64], diff[3:0]});
            if (in_valid && in_ready) q.push_back(model(a_i, b_i, bin_i));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got diff %h expected no output", diff);
                end else begin
                    e = q.pop_front();
                    chk("diff", diff, e.d);
                    chk("flags", {61'd0, bout, ovf, zero}, {61'd0, e.bo, e.ov, e.z});
                    if (n_out == phase_base) first_cyc = cyc;
                    last_cyc = cyc;
                    n_out++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {bout, ovf, zero, diff};
        end
    end

    // One directed op on an idle pipe; checks latency and literal results
    task automatic run_one(input string name, input logic [63:0] x, input logic [63:0] y, input logic bi,
                           input logic [63:0] ed, input logic ebo, input logic eov, input logic ez);
        int n;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_i = x; b_i = y; bin_i = bi;
        chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'd4);
        chk({name, "_diff"}, diff, ed);
        chk({name, "_flags"}, {61'd0, bout, ovf, zero}, {61'd0, ebo, eov, ez});
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = '1;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        int n;
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_i = '0; b_i = '0; bin_i = 1'b0;

        // Reset state
        @(posedge clk); #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_diff", diff, 64'd0);
        chk("rst_flags", {61'd0, bout, ovf, zero}, 64'd0);
        #5 rst_n = 1'b1;
        #1 chk("rel_in_ready_before_clk", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        chk("rel_in_ready_after_clk", {63'd0, in_ready}, 64'd1);

        // T1..T3 directed literals
        run_one("t1_ripple", 64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_one("t2_underflow", 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_one("t3_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_one("t3_zero", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        run_one("slice_edge", 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0000, 1'b1,
                64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0);
        run_one("borrow_top", 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);
        drain(20);

        // T4 throughput
        phase_base = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            a_i = rnd64(); b_i = rnd64(); bin_i = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain(50);
        chk("t4_count", 64'(n_out - phase_base), 64'd1000);
        chk("t4_one_per_cycle", 64'(last_cyc - first_cyc), 64'd999);

        // T5 backpressure
        phase_base = n_out;
        seen = 0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 9) < 7);
            a_i = rnd64(); b_i = rnd64(); bin_i = 1'($urandom_range(0, 1));
            if (out_valid && !out_ready) seen++;
        end
        drain(100);
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL t5_stall_seen got %0d expected nonzero", seen);
        end

        // T6 reset mid-flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            a_i = 64'hDEAD_0000_0000_0000 + 64'(i); b_i = 64'd3; bin_i = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk("t6_out_valid_in_reset", {63'd0, out_valid}, 64'd0);
        chk("t6_in_ready_in_reset", {63'd0, in_ready}, 64'd0);
        #4 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chk("t6_no_stale", 64'(n), 64'd0);
        run_one("t6_after", 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0011, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
